itmult_arb2: RTL and testbench

//  Sequencer and round-robin arbiter that shares one iterative multiplier (itmult) between two requesters.

---
 rtl/itmult_arb2_pkg.sv | 18 +
 rtl/itmult_arb2_if.sv | 40 ++++
 rtl/itmult_arb2_rr_arb2.sv | 22 ++
 rtl/itmult_arb2.sv | 134 +++++++++++++
 tb/tb_itmult_arb2.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/itmult_arb2_pkg.sv
// Shared definitions for the itmult_arb2 two-client multiplier sequencer.
//   state_e    sequencer states (encodings fixed; other blocks decode them)
//   cnt_width  width of the RUN-cycle counter for a given timeout
package itmult_arb2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Counter must hold 0..tmo; never collapse to a zero-width vector.
  function automatic int unsigned cnt_width(input int unsigned tmo);
    return (tmo < 1) ? 1 : $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/itmult_arb2_if.sv
// Bundle of the client-side and multiplier-side signals of itmult_arb2.
//   slave  : the arbiter (consumes requests and itmult results, drives grants/results/itmult)
//   master : the environment (clients plus itmult)
// Client side : req0/a0/b0, req1/a1/b1 in; gnt0/gnt1, rsp0/rsp1, p, err, busy out.
// itmult side : mul_a, mul_b, mul_start out; mul_fin, mul_hm, mul_lm in.
interface itmult_arb2_if #(
  parameter int unsigned SIZE = 6
);

  logic              req0;
  logic [SIZE-1:0]   a0;
  logic [SIZE-1:0]   b0;
  logic              req1;
  logic [SIZE-1:0]   a1;
  logic [SIZE-1:0]   b1;
  logic              gnt0;
  logic              gnt1;
  logic              rsp0;
  logic              rsp1;
  logic [2*SIZE-1:0] p;
  logic              err;
  logic              busy;
  logic [SIZE-1:0]   mul_a;
  logic [SIZE-1:0]   mul_b;
  logic              mul_start;
  logic              mul_fin;
  logic [SIZE-1:0]   mul_hm;
  logic [SIZE-1:0]   mul_lm;

  modport slave (
    input  req0, a0, b0, req1, a1, b1, mul_fin, mul_hm, mul_lm,
    output gnt0, gnt1, rsp0, rsp1, p, err, busy, mul_a, mul_b, mul_start
  );

  modport master (
    output req0, a0, b0, req1, a1, b1, mul_fin, mul_hm, mul_lm,
    input  gnt0, gnt1, rsp0, rsp1, p, err, busy, mul_a, mul_b, mul_start
  );

endinterface

// File: rtl/itmult_arb2_rr_arb2.sv
// Combinational two-way round-robin pick.
//   ptr  : preferred requester when both request (0 or 1)
//   req0 : requester 0 request
//   req1 : requester 1 request
//   gnt  : index of the winner; only meaningful when req0 | req1
module itmult_arb2_rr_arb2 (
  input  logic ptr,
  input  logic req0,
  input  logic req1,
  output logic gnt
);

  always_comb begin
    gnt = 1'b0;
    if (req0 && req1) begin
      gnt = ptr;
    end else if (req1) begin
      gnt = 1'b1;
    end
  end

endmodule

// File: rtl/itmult_arb2.sv
// Sequencer and round-robin arbiter sharing one iterative multiplier (itmult)
// between two requesters. The winner's operands are latched, itmult is loaded
// (start low for one cycle) and then run (start high) until fin or timeout,
// and {HM,LM} is returned to the winner with a one-cycle rsp pulse.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    itmult_arb2_if.slave: client requests/results and itmult handshake
module itmult_arb2
  import itmult_arb2_pkg::*;
#(
  parameter int unsigned SIZE = 6,
  parameter int unsigned TMO  = SIZE + 2
) (
  input logic            clk,
  input logic            reset,
  itmult_arb2_if.slave   bus
);

  localparam int unsigned CW = cnt_width(TMO);
  // The edge that closes the TMO-th RUN cycle without fin aborts the op.
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

  state_e            state_q, state_d;
  logic              win_q, win_d;
  logic              ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SIZE-1:0]   opa_q, opa_d;
  logic [SIZE-1:0]   opb_q, opb_d;
  logic [2*SIZE-1:0] p_q, p_d;
  logic              err_q, err_d;
  logic              pick;
  logic              any_req;
  logic              run_tmo;

  assign any_req = bus.req0 | bus.req1;
  assign run_tmo = (cnt_q == CNT_LAST);

  itmult_arb2_rr_arb2 u_rr (
    .ptr  (ptr_q),
    .req0 (bus.req0),
    .req1 (bus.req1),
    .gnt  (pick)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; fin has priority over the timeout at the same edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (any_req) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  if (bus.mul_fin || run_tmo) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: winner, pointer, operands, counter, result.
  always_comb begin
    win_d = win_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    opa_d = opa_q;
    opb_d = opb_q;
    p_d   = p_q;
    err_d = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          win_d = pick;
          opa_d = pick ? bus.a1 : bus.a0;
          opb_d = pick ? bus.b1 : bus.b0;
        end
      end
      ST_LOAD: cnt_d = '0;
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.mul_fin) begin
          p_d   = {bus.mul_hm, bus.mul_lm};
          err_d = 1'b0;
        end else if (run_tmo) begin
          p_d   = '0;
          err_d = 1'b1;
        end
      end
      ST_DONE: ptr_d = ~win_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q <= 1'b0;
      ptr_q <= 1'b0;
      cnt_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      p_q   <= '0;
      err_q <= 1'b0;
    end else begin
      win_q <= win_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      p_q   <= p_d;
      err_q <= err_d;
    end
  end

  // Outputs decoded from state; win_q is only looked at while busy.
  always_comb begin
    bus.busy      = (state_q != ST_IDLE);
    bus.gnt0      = (state_q != ST_IDLE) && !win_q;
    bus.gnt1      = (state_q != ST_IDLE) && win_q;
    bus.rsp0      = (state_q == ST_DONE) && !win_q;
    bus.rsp1      = (state_q == ST_DONE) && win_q;
    bus.mul_start = (state_q == ST_RUN);
    bus.mul_a     = opa_q;
    bus.mul_b     = opb_q;
    bus.p         = p_q;
    bus.err       = err_q;
  end

endmodule

// File: tb/tb_itmult_arb2.sv
module tb_itmult_arb2;

  localparam int unsigned SIZE = 4;
  localparam int unsigned TMO  = SIZE + 2;
  localparam int LAT_OK  = SIZE + 3;  // cycles from req to rsp with a working itmult
  localparam int LAT_TMO = TMO + 2;   // LOAD + TMO RUN cycles + DONE

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   fin_kill = 1'b0;
  int   errors = 0;
  int   checks = 0;

  itmult_arb2_if #(.SIZE(SIZE)) bus ();

  itmult_arb2 #(.SIZE(SIZE), .TMO(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural itmult: start low reloads, fin after SIZE+1 running cycles.
  int mcnt;
  logic [2*SIZE-1:0] prod;
  always @(posedge clk) begin
    if (!bus.mul_start) mcnt <= 0;
    else if (mcnt != SIZE) mcnt <= mcnt + 1;
  end
  assign prod        = bus.mul_a * bus.mul_b;
  assign bus.mul_hm  = prod[2*SIZE-1:SIZE];
  assign bus.mul_lm  = prod[SIZE-1:0];
  assign bus.mul_fin = !fin_kill && bus.mul_start && (mcnt == SIZE);

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Handshake legality every cycle: one-hot gnt/rsp, rsp only to the owner.
  always @(negedge clk) begin
    if (reset) begin
      check("handshake_legal",
            int'({bus.gnt0 & bus.gnt1, bus.rsp0 & bus.rsp1,
                  bus.rsp0 & ~bus.gnt0, bus.rsp1 & ~bus.gnt1}), 0);
    end
  end

  typedef struct {
    int who;
    int lat;
    int p;
    int err;
  } rsp_t;
  rsp_t got_q[$];
  logic [1:0] first_gnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise the requested reqs, wait for every rsp, drop each req on its rsp,
  // then step into the following idle cycle. chg_n > 0 rewrites a0 mid-op.
  task automatic serve(input bit r0, input bit r1, input int x0, input int y0,
                       input int x1, input int y1, input int chg_n);
    int   pend;
    rsp_t r;
    got_q.delete();
    first_gnt = 2'b00;
    bus.a0 = x0[SIZE-1:0];
    bus.b0 = y0[SIZE-1:0];
    bus.a1 = x1[SIZE-1:0];
    bus.b1 = y1[SIZE-1:0];
    bus.req0 = r0;
    bus.req1 = r1;
    pend = int'(r0) + int'(r1);
    for (int n = 1; n <= 60 && pend > 0; n++) begin
      tick();
      if (n == 1) first_gnt = {bus.gnt1, bus.gnt0};
      if (n == chg_n) bus.a0 = 1;
      if (bus.rsp0) begin
        r.who = 0; r.lat = n; r.p = int'(bus.p); r.err = int'(bus.err);
        got_q.push_back(r);
        bus.req0 = 1'b0;
        pend--;
      end
      if (bus.rsp1) begin
        r.who = 1; r.lat = n; r.p = int'(bus.p); r.err = int'(bus.err);
        got_q.push_back(r);
        bus.req1 = 1'b0;
        pend--;
      end
    end
    if (pend > 0) begin
      check("rsp_timeout", pend, 0);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
    end
    tick();
  endtask

  task automatic expect_op(input string tag, input int idx, input int who, input int p,
                           input int err, input int lat);
    if (idx < got_q.size()) begin
      check({tag, "_who"}, got_q[idx].who, who);
      check({tag, "_p"},   got_q[idx].p,   p);
      check({tag, "_err"}, got_q[idx].err, err);
      check({tag, "_lat"}, got_q[idx].lat, lat);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
  endtask

  typedef struct {
    bit rst;
    bit r0, r1;
    int x0, y0, x1, y1;
    int chg;
    int n;
    int w0, p0, e0, l0;
    int w1, p1, e1, l1;
  } vec_t;
  vec_t vt[6];

  initial begin
    int pref, first, second, lat, nexp;
    bit r0, r1, stub;
    int x0, y0, x1, y1, pe0, pe1;

    //          rst r0 r1  x0  y0  x1  y1 chg n  w0  p0 e0 l0   w1 p1 e1 l1
    vt[0] = '{1, 1, 0, 12, 12,  0,  0, 0, 1, 0, 144, 0, 7,  0,  0, 0, 0};
    vt[1] = '{1, 1, 1,  3,  5,  7,  9, 0, 2, 0,  15, 0, 7,  1, 63, 0, 15};
    vt[2] = '{0, 1, 1,  2, 13, 11,  6, 0, 2, 0,  26, 0, 7,  1, 66, 0, 15};
    vt[3] = '{0, 1, 1,  9,  9,  4,  8, 0, 2, 0,  81, 0, 7,  1, 32, 0, 15};
    vt[4] = '{0, 1, 0, 10, 10,  0,  0, 3, 1, 0, 100, 0, 7,  0,  0, 0, 0};
    vt[5] = '{0, 1, 1,  0, 15, 15,  0, 0, 2, 1,   0, 0, 7,  0,  0, 0, 15};

    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    reset = 1'b0;
    tick();
    check("reset_flags", int'({bus.gnt0, bus.gnt1, bus.rsp0, bus.rsp1, bus.err,
                                bus.busy, bus.mul_start}), 0);
    check("reset_p", int'(bus.p), 0);
    check("reset_mul_ab", int'({bus.mul_a, bus.mul_b}), 0);
    #1 reset = 1'b1;
    tick();

    // Directed vectors: single op, both at once, alternation, latched operands.
    for (int i = 0; i < 6; i++) begin
      if (vt[i].rst) do_reset();
      serve(vt[i].r0, vt[i].r1, vt[i].x0, vt[i].y0, vt[i].x1, vt[i].y1, vt[i].chg);
      check($sformatf("vec%0d_count", i), got_q.size(), vt[i].n);
      check($sformatf("vec%0d_first_gnt", i), int'(first_gnt), vt[i].w0 == 0 ? 1 : 2);
      expect_op($sformatf("vec%0d_op0", i), 0, vt[i].w0, vt[i].p0, vt[i].e0, vt[i].l0);
      if (vt[i].n > 1)
        expect_op($sformatf("vec%0d_op1", i), 1, vt[i].w1, vt[i].p1, vt[i].e1, vt[i].l1);
    end

    // Stuck multiplier: timeout with err, then a normal op recovers.
    fin_kill = 1'b1;
    serve(1, 0, 5, 5, 0, 0, 0);
    check("tmo_count", got_q.size(), 1);
    expect_op("tmo", 0, 0, 0, 1, LAT_TMO);
    fin_kill = 1'b0;
    serve(0, 1, 0, 0, 2, 3, 0);
    check("after_tmo_count", got_q.size(), 1);
    expect_op("after_tmo", 0, 1, 6, 0, LAT_OK);

    // Reset during RUN clears everything at once; next op runs clean.
    bus.a0 = 4'd15; bus.b0 = 4'd15; bus.req0 = 1'b1;
    repeat (3) tick();
    check("mid_run_state", int'({bus.busy, bus.mul_start, bus.gnt0}), 7);
    reset = 1'b0;
    #1;
    check("async_reset_flags", int'({bus.gnt0, bus.gnt1, bus.rsp0, bus.rsp1, bus.err,
                                      bus.busy, bus.mul_start}), 0);
    check("async_reset_mul_ab", int'({bus.mul_a, bus.mul_b}), 0);
    bus.req0 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    serve(1, 0, 15, 15, 0, 0, 0);
    check("post_reset_count", got_q.size(), 1);
    expect_op("post_reset", 0, 0, 225, 0, LAT_OK);

    // Random transactions against a transaction-level model.
    do_reset();
    pref = 0;
    for (int k = 0; k < 25; k++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      x0 = int'($urandom_range(0, 15)); y0 = int'($urandom_range(0, 15));
      x1 = int'($urandom_range(0, 15)); y1 = int'($urandom_range(0, 15));
      stub = ($urandom_range(0, 7) == 0);
      fin_kill = stub;
      lat = stub ? LAT_TMO : LAT_OK;
      pe0 = stub ? 0 : x0 * y0;
      pe1 = stub ? 0 : x1 * y1;
      if (r0 && r1) begin
        first = pref; second = 1 - pref; nexp = 2;
        pref = first;  // the requester served last loses the next tie
      end else begin
        first = r1 ? 1 : 0; second = 0; nexp = 1;
        pref = 1 - first;
      end
      serve(r0, r1, x0, y0, x1, y1, 0);
      check($sformatf("rnd%0d_count", k), got_q.size(), nexp);
      expect_op($sformatf("rnd%0d_op0", k), 0, first, first ? pe1 : pe0, int'(stub), lat);
      if (nexp > 1)
        expect_op($sformatf("rnd%0d_op1", k), 1, second, second ? pe1 : pe0, int'(stub),
                  2 * lat + 1);
      fin_kill = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
